// File: rtl/priority_resolver_n.sv
// rtl/priority_resolver_n.sv - parametrised interrupt priority resolver with nested in-service tracking
//
// Resolves NUM_IRQ request lines into one channel index over a two-pulse
// acknowledge handshake. It supports edge or level capture, masking, fully
// nested in-service blocking, a rotating lowest-priority pointer, specific
// and non-specific EOI, and automatic EOI.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   ir                     raw request lines
//   ltim                   1 = level capture, 0 = edge capture
//   imr_wr, imr_data       one-cycle mask load
//   rotate_mode, aeoi      rotate on automatic EOI, automatic EOI enable
//   eoi_valid              EOI command strobe
//   eoi_specific, eoi_id   specific channel select for the EOI
//   eoi_rotate             EOI also moves the lowest-priority pointer
//   setprio_valid/_id      load the lowest-priority pointer
//   inta                   acknowledge pulse (first and second)
//   int_o                  request to the CPU
//   vec_valid, vec         acknowledged channel after the second pulse
//   irr, isr, imr          request, in-service and mask registers

module priority_resolver_n #(
    parameter  int NUM_IRQ = 8,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] ir,
    input  logic               ltim,
    input  logic               imr_wr,
    input  logic [NUM_IRQ-1:0] imr_data,
    input  logic               rotate_mode,
    input  logic               aeoi,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               setprio_valid,
    input  logic [ID_W-1:0]    setprio_id,
    input  logic               inta,
    output logic               int_o,
    output logic               vec_valid,
    output logic [ID_W-1:0]    vec,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] imr
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK2 = 1'b1
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE     = NUM_IRQ'(1);
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_IRQ - 1);

    // Channel that sits at a given rank (0 = highest) for pointer lp_v.
    function automatic logic [ID_W-1:0] chan_of(input logic [ID_W-1:0] lp_v, input int rank);
        int c;
        c = int'(lp_v) + 1 + rank;
        if (c >= NUM_IRQ) begin
            c = c - NUM_IRQ;
        end
        return ID_W'(c);
    endfunction

    // Reorders a per-channel vector so that bit k is the channel at rank k.
    function automatic logic [NUM_IRQ-1:0] by_rank(input logic [NUM_IRQ-1:0] v,
                                                   input logic [ID_W-1:0]    lp_v);
        logic [NUM_IRQ-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            r[k] = v[chan_of(lp_v, k)];
        end
        return r;
    endfunction

    // Lowest set bit index; 0 when nothing is set (callers qualify with |v).
    function automatic logic [ID_W-1:0] first_set(input logic [NUM_IRQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (v[k]) begin
                r = ID_W'(k);
            end
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] ir_q;
    logic [ID_W-1:0]    lp_q, lp_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic               spur_q, spur_d;

    logic [NUM_IRQ-1:0] irr_d, isr_d, imr_d;
    logic [ID_W-1:0]    vec_d;
    logic               vec_valid_d, int_d;

    logic               ack_first, ack_second;

    // Priority resolution against the current lowest-priority pointer.
    logic [NUM_IRQ-1:0] req, req_rank_vec, isr_rank_vec;
    logic               req_any, isr_any, cand_valid;
    logic [ID_W-1:0]    req_rank, isr_rank, cand_id, isr_top_id;

    assign req          = irr & ~imr;
    assign req_rank_vec = by_rank(req, lp_q);
    assign isr_rank_vec = by_rank(isr, lp_q);
    assign req_any      = |req;
    assign isr_any      = |isr;
    assign req_rank     = first_set(req_rank_vec);
    assign isr_rank     = first_set(isr_rank_vec);
    assign cand_id      = chan_of(lp_q, int'(req_rank));
    assign isr_top_id   = chan_of(lp_q, int'(isr_rank));
    // Masked isr bits are deliberately left in isr_rank_vec so they keep
    // blocking lower-priority requests.
    assign cand_valid   = req_any && (!isr_any || (req_rank < isr_rank));

    // Handshake sequencing.
    always_comb begin
        state_d    = state_q;
        ack_first  = 1'b0;
        ack_second = 1'b0;
        case (state_q)
            IDLE: begin
                if (inta) begin
                    state_d   = ACK2;
                    ack_first = 1'b1;
                end
            end
            ACK2: begin
                if (inta) begin
                    state_d    = IDLE;
                    ack_second = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register next-state values.
    logic [NUM_IRQ-1:0] edge_det, ack_set, eoi_clr, aeoi_clr;
    logic               eoi_hit, eoi_id_ok, setprio_ok, aeoi_live;
    logic [ID_W-1:0]    eoi_chan;

    always_comb begin
        edge_det   = ir & ~ir_q;
        ack_set    = '0;
        eoi_clr    = '0;
        aeoi_clr   = '0;
        eoi_hit    = 1'b0;
        eoi_chan   = eoi_id;
        // Ids beyond the channel count (non power-of-two NUM_IRQ) are ignored
        // so the priority pointer always stays in range.
        eoi_id_ok  = int'(eoi_id) < NUM_IRQ;
        setprio_ok = int'(setprio_id) < NUM_IRQ;
        aeoi_live  = ack_second && aeoi && !spur_q;

        if (ack_first && cand_valid) begin
            ack_set = ONE << cand_id;
        end

        // A fresh edge on the acknowledged bit re-arms the request.
        if (ltim) begin
            irr_d = (ir & ~ack_set) | edge_det;
        end else begin
            irr_d = (irr & ir & ~ack_set) | edge_det;
        end

        if (eoi_valid) begin
            if (eoi_specific) begin
                if (eoi_id_ok) begin
                    eoi_clr = ONE << eoi_id;
                    eoi_hit = 1'b1;
                end
            end else if (isr_any) begin
                eoi_clr  = ONE << isr_top_id;
                eoi_chan = isr_top_id;
                eoi_hit  = 1'b1;
            end
        end

        if (aeoi_live) begin
            aeoi_clr = ONE << sel_q;
        end

        // Clears first, then the acknowledge set, so a same-bit set wins.
        isr_d = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        imr_d = imr_wr ? imr_data : imr;

        // Pointer writers in rising precedence: setprio, EOI rotate, AEOI rotate.
        lp_d = lp_q;
        if (setprio_valid && setprio_ok) begin
            lp_d = setprio_id;
        end
        if (eoi_valid && eoi_rotate && eoi_hit) begin
            lp_d = eoi_chan;
        end
        if (aeoi_live && rotate_mode) begin
            lp_d = sel_q;
        end

        sel_d  = sel_q;
        spur_d = spur_q;
        if (ack_first) begin
            sel_d  = cand_valid ? cand_id : LAST_ID;
            spur_d = !cand_valid;
        end

        vec_d       = ack_second ? sel_q : vec;
        vec_valid_d = ack_second;
        int_d       = (state_q == IDLE) && !inta && cand_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_q      <= ir;
            irr       <= '0;
            isr       <= '0;
            imr       <= '0;
            lp_q      <= LAST_ID;
            sel_q     <= '0;
            spur_q    <= 1'b0;
            vec       <= '0;
            vec_valid <= 1'b0;
            int_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir;
            irr       <= irr_d;
            isr       <= isr_d;
            imr       <= imr_d;
            lp_q      <= lp_d;
            sel_q     <= sel_d;
            spur_q    <= spur_d;
            vec       <= vec_d;
            vec_valid <= vec_valid_d;
            int_o     <= int_d;
        end
    end

endmodule

// File: tb/tb_priority_resolver_n.sv
// tb/tb_priority_resolver_n.sv - directed bench for priority_resolver_n

module tb_priority_resolver_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ltim, aeoi, rotate_mode, inta;
    logic       eoi_valid, eoi_specific, eoi_rotate, setprio_valid;

    logic [7:0] ir8, imr_data8;
    logic       imr_wr8;
    logic [2:0] eoi_id8, setprio_id8;
    logic       int8, vv8;
    logic [2:0] vec8;
    logic [7:0] irr8, isr8, imr8;

    logic [15:0] ir16, imr_data16;
    logic        imr_wr16;
    logic [3:0]  eoi_id16, setprio_id16;
    logic        int16, vv16;
    logic [3:0]  vec16;
    logic [15:0] irr16, isr16, imr16;

    priority_resolver_n #(.NUM_IRQ(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ir(ir8), .ltim(ltim),
        .imr_wr(imr_wr8), .imr_data(imr_data8),
        .rotate_mode(rotate_mode), .aeoi(aeoi),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate),
        .eoi_id(eoi_id8), .setprio_valid(setprio_valid), .setprio_id(setprio_id8),
        .inta(inta), .int_o(int8), .vec_valid(vv8), .vec(vec8),
        .irr(irr8), .isr(isr8), .imr(imr8)
    );

    priority_resolver_n #(.NUM_IRQ(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ir(ir16), .ltim(ltim),
        .imr_wr(imr_wr16), .imr_data(imr_data16),
        .rotate_mode(rotate_mode), .aeoi(aeoi),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate),
        .eoi_id(eoi_id16), .setprio_valid(setprio_valid), .setprio_id(setprio_id16),
        .inta(inta), .int_o(int16), .vec_valid(vv16), .vec(vec16),
        .irr(irr16), .isr(isr16), .imr(imr16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] ir;
        logic       ltim;
        logic       inta;
        logic       eoi_v;
        logic       eoi_spec;
        logic [2:0] eoi_id;
        logic       imr_wr;
        logic [7:0] imr_data;
        logic       e_int;
        logic       e_vv;
        logic [2:0] e_vec;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic [7:0] e_imr;
    } row_t;

    localparam int NROWS = 34;
    row_t tbl [NROWS];

    function automatic row_t mk(input int ir, input int lt, input int ia, input int ev,
                                input int es, input int eid, input int mw, input int md,
                                input int xi, input int xv, input int xvec, input int xirr,
                                input int xisr, input int ximr);
        row_t r;
        r.ir = 8'(ir);       r.ltim = 1'(lt);      r.inta = 1'(ia);
        r.eoi_v = 1'(ev);    r.eoi_spec = 1'(es);  r.eoi_id = 3'(eid);
        r.imr_wr = 1'(mw);   r.imr_data = 8'(md);
        r.e_int = 1'(xi);    r.e_vv = 1'(xv);      r.e_vec = 3'(xvec);
        r.e_irr = 8'(xirr);  r.e_isr = 8'(xisr);   r.e_imr = 8'(ximr);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_int16(input string name);
        for (int n = 0; n < 8; n++) begin
            tick();
            if (int16) break;
        end
        chk(name, 32'(int16), 32'd1);
    endtask

    task automatic ack16(input string name, input int exp_vec);
        inta = 1'b1;
        tick();
        chk({name, " isr after inta1"}, 32'(isr16), 32'(16'h1 << exp_vec));
        chk({name, " int_o after inta1"}, 32'(int16), 32'd0);
        tick();
        inta = 1'b0;
        chk({name, " vec_valid"}, 32'(vv16), 32'd1);
        chk({name, " vec"}, 32'(vec16), 32'(exp_vec));
        chk({name, " isr after aeoi"}, 32'(isr16), 32'd0);
    endtask

    initial begin
        //          ir  lt ia ev es id mw md   int vv vec irr   isr   imr
        tbl[0]  = mk('h24, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h24, 'h00, 'h00);
        tbl[1]  = mk('h24, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 'h24, 'h00, 'h00);
        tbl[2]  = mk('h24, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 'h20, 'h04, 'h00);
        tbl[3]  = mk('h24, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h20, 'h04, 'h00);
        tbl[4]  = mk('h24, 0, 1, 0, 0, 0, 0, 0,  0, 1, 2, 'h20, 'h04, 'h00);
        tbl[5]  = mk('h24, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 'h20, 'h04, 'h00);
        tbl[6]  = mk('h26, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 'h22, 'h04, 'h00);
        tbl[7]  = mk('h26, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 'h22, 'h04, 'h00);
        tbl[8]  = mk('h26, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2, 'h20, 'h06, 'h00);
        tbl[9]  = mk('h26, 0, 1, 0, 0, 0, 0, 0,  0, 1, 1, 'h20, 'h06, 'h00);
        tbl[10] = mk('h26, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 'h20, 'h04, 'h00);
        tbl[11] = mk('h26, 0, 0, 1, 1, 2, 0, 0,  0, 0, 1, 'h20, 'h00, 'h00);
        tbl[12] = mk('h26, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 'h20, 'h00, 'h00);
        tbl[13] = mk('h00, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 'h00, 'h00, 'h00);
        tbl[14] = mk('h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h00, 'h00, 'h00);
        tbl[15] = mk('h08, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 'h08, 'h00, 'h00);
        tbl[16] = mk('h00, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 'h00, 'h00, 'h00);
        tbl[17] = mk('h00, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 'h00, 'h00, 'h00);
        tbl[18] = mk('h00, 0, 1, 0, 0, 0, 0, 0,  0, 1, 7, 'h00, 'h00, 'h00);
        tbl[19] = mk('h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 'h00, 'h00, 'h00);
        tbl[20] = mk('h01, 1, 0, 0, 0, 0, 1, 1,  0, 0, 7, 'h01, 'h00, 'h01);
        tbl[21] = mk('h01, 1, 0, 0, 0, 0, 0, 0,  0, 0, 7, 'h01, 'h00, 'h01);
        tbl[22] = mk('h01, 1, 0, 0, 0, 0, 1, 0,  0, 0, 7, 'h01, 'h00, 'h00);
        tbl[23] = mk('h01, 1, 0, 0, 0, 0, 0, 0,  1, 0, 7, 'h01, 'h00, 'h00);
        tbl[24] = mk('h01, 1, 1, 0, 0, 0, 0, 0,  0, 0, 7, 'h00, 'h01, 'h00);
        tbl[25] = mk('h01, 1, 0, 0, 0, 0, 0, 0,  0, 0, 7, 'h01, 'h01, 'h00);
        tbl[26] = mk('h01, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 'h01, 'h01, 'h00);
        tbl[27] = mk('h00, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 'h00, 'h00, 'h00);
        tbl[28] = mk('h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h00, 'h00, 'h00);
        tbl[29] = mk('h04, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h04, 'h00, 'h00);
        tbl[30] = mk('h04, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 'h04, 'h00, 'h00);
        tbl[31] = mk('h04, 0, 1, 1, 1, 2, 0, 0,  0, 0, 0, 'h00, 'h04, 'h00);
        tbl[32] = mk('h04, 0, 1, 0, 0, 0, 0, 0,  0, 1, 2, 'h00, 'h04, 'h00);
        tbl[33] = mk('h04, 0, 0, 1, 1, 2, 0, 0,  0, 0, 2, 'h00, 'h00, 'h00);

        rst_n = 1'b0; ltim = 1'b0; aeoi = 1'b0; rotate_mode = 1'b0; inta = 1'b0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; setprio_valid = 1'b0;
        ir8 = '0; imr_wr8 = 1'b0; imr_data8 = '0; eoi_id8 = '0; setprio_id8 = '0;
        ir16 = '0; imr_wr16 = 1'b0; imr_data16 = '0; eoi_id16 = '0; setprio_id16 = '0;

        tick();
        tick();
        chk("reset int_o", 32'(int8), 32'd0);
        chk("reset vec_valid", 32'(vv8), 32'd0);
        chk("reset vec", 32'(vec8), 32'd0);
        chk("reset irr", 32'(irr8), 32'd0);
        chk("reset isr", 32'(isr8), 32'd0);
        chk("reset imr", 32'(imr8), 32'd0);
        chk("reset isr16", 32'(isr16), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NROWS; i++) begin
            ir8 = tbl[i].ir;          ltim = tbl[i].ltim;       inta = tbl[i].inta;
            eoi_valid = tbl[i].eoi_v; eoi_specific = tbl[i].eoi_spec;
            eoi_id8 = tbl[i].eoi_id;  imr_wr8 = tbl[i].imr_wr;  imr_data8 = tbl[i].imr_data;
            tick();
            chk($sformatf("row%0d int_o", i), 32'(int8), 32'(tbl[i].e_int));
            chk($sformatf("row%0d vec_valid", i), 32'(vv8), 32'(tbl[i].e_vv));
            chk($sformatf("row%0d vec", i), 32'(vec8), 32'(tbl[i].e_vec));
            chk($sformatf("row%0d irr", i), 32'(irr8), 32'(tbl[i].e_irr));
            chk($sformatf("row%0d isr", i), 32'(isr8), 32'(tbl[i].e_isr));
            chk($sformatf("row%0d imr", i), 32'(imr8), 32'(tbl[i].e_imr));
        end
        inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; imr_wr8 = 1'b0; ltim = 1'b0;

        // Reset during ACK2 aborts the handshake.
        ir8 = 8'h02;
        tick();
        tick();
        chk("abort int_o before ack", 32'(int8), 32'd1);
        inta = 1'b1;
        tick();
        chk("abort isr after inta1", 32'(isr8), 32'h02);
        rst_n = 1'b0;
        tick();
        chk("abort vec_valid", 32'(vv8), 32'd0);
        chk("abort vec", 32'(vec8), 32'd0);
        chk("abort irr", 32'(irr8), 32'd0);
        chk("abort isr", 32'(isr8), 32'd0);
        chk("abort imr", 32'(imr8), 32'd0);
        chk("abort int_o", 32'(int8), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post-abort inta is first", 32'(vv8), 32'd0);
        chk("post-abort no edge at exit", 32'(isr8), 32'd0);
        inta = 1'b0;
        tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("post-abort spurious vec_valid", 32'(vv8), 32'd1);
        chk("post-abort spurious vec", 32'(vec8), 32'd7);

        // AEOI with rotation on the 16-channel instance.
        rst_n = 1'b0; ir8 = '0; ir16 = '0;
        tick();
        tick();
        rst_n = 1'b1; aeoi = 1'b1; rotate_mode = 1'b1;
        ir16 = 16'h0008;
        wait_int16("aeoi ch3 int_o");
        ack16("aeoi ch3", 3);
        ir16 = 16'h0000;
        tick();
        ir16 = 16'h0019;
        wait_int16("rot ch4 int_o");
        ack16("rot ch4", 4);
        wait_int16("rot ch0 int_o");
        ack16("rot ch0", 0);
        wait_int16("rot ch3 int_o");
        ack16("rot ch3", 3);
        ir16 = 16'h0000;
        tick();
        setprio_valid = 1'b1; setprio_id16 = 4'd7;
        tick();
        setprio_valid = 1'b0;
        ir16 = 16'h0041;
        wait_int16("setprio int_o");
        ack16("setprio ch0", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/priority_resolver_n.md
# priority_resolver_n

Parametrised, synchronous interrupt priority resolver for the PIC datapath. It generalises the 8-input resolver to `NUM_IRQ` channels and runs on a single clock with registered state. It supports edge and level triggering, masking, fully nested in-service tracking, fixed and rotating priority, specific and non-specific EOI, and AEOI. It sits between the IR pins, the control logic (ICW/OCW decode) and the read/write logic, and returns a channel index on a two-pulse INTA handshake.

## Interface
- NUM_IRQ, 8, number of request channels (2..32)
- ID_W, $clog2(NUM_IRQ), width of channel index (derived localparam, not overridable)

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- ir  in  NUM_IRQ  raw interrupt request lines
- ltim  in  1  1 = level-triggered, 0 = edge-triggered
- imr_wr  in  1  one-cycle strobe: load imr from imr_data
- imr_data  in  NUM_IRQ  new mask, 1 = masked
- rotate_mode  in  1  1 = automatic rotation on AEOI, 0 = no automatic rotation
- aeoi  in  1  automatic end of interrupt enable
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = clear isr[eoi_id], 0 = clear highest-priority isr bit
- eoi_rotate  in  1  with eoi_valid: set lowest priority to the cleared channel
- eoi_id  in  ID_W  channel for specific EOI
- setprio_valid  in  1  one-cycle strobe: lowest priority := setprio_id
- setprio_id  in  ID_W  new lowest-priority channel
- inta  in  1  acknowledge pulse; high for exactly one cycle per CPU INTA
- int_o  out  1  interrupt request to CPU
- vec_valid  out  1  one-cycle strobe: vec holds acknowledged channel
- vec  out  ID_W  acknowledged channel index
- irr  out  NUM_IRQ  interrupt request register
- isr  out  NUM_IRQ  in-service register
- imr  out  NUM_IRQ  interrupt mask register

## Operation
- Reset (rst_n low at a rising edge):
  - irr, isr, imr, vec, vec_valid and int_o are 0.
  - lp (lowest-priority pointer) = NUM_IRQ-1.
  - State is IDLE.
  - ir_q loads ir, so an input already high produces no edge at reset exit.
- Request capture:
  - Edge mode: irr[i] sets on ir[i] & ~ir_q[i], clears on the first-INTA ack of i, and clears if ir[i] is low while not yet acked.
  - Level mode: irr[i] follows ir[i] each cycle, except that the ack clear applies in the ack cycle.
- Priority order: lp+1, lp+2, ... modulo NUM_IRQ; lp itself is lowest. With lp = NUM_IRQ-1, channel 0 is highest.
- Candidate: the highest-priority set bit of irr & ~imr.
  - Fully nested rule: the candidate is valid only if it ranks above the highest-priority set isr bit, or isr is 0.
  - Masked isr bits still block lower-priority channels.
- int_o is a registered copy of candidate-valid in IDLE. It is forced to 0 in ACK2.
- FSM states:
  - IDLE: on inta, latch sel := candidate and go to ACK2.
    - If a candidate is valid: set isr[sel] and clear irr[sel].
    - If no candidate is valid (spurious): sel := NUM_IRQ-1, and isr/irr are unchanged.
  - ACK2: on inta, vec := sel, pulse vec_valid, and return to IDLE.
    - If aeoi and not spurious, clear isr[sel].
    - If aeoi, rotate_mode and not spurious, lp := sel.
- EOI:
  - Non-specific clears the highest-priority set isr bit; it is a no-op if isr is 0.
  - Specific clears isr[eoi_id].
  - With eoi_rotate, lp := cleared channel. A non-specific EOI with isr 0 leaves lp unchanged.
- setprio_valid: lp := setprio_id. It is ignored in a cycle where eoi_rotate also writes lp; the EOI wins.
- Simultaneous events in one cycle:
  - EOI clear is applied before the ack set, so a same-bit set wins.
  - The ack uses the pre-write imr.
  - A new edge on a bit being acked leaves irr set.
  - AEOI rotation has priority over setprio and EOI rotation.
- rst_n low in ACK2 aborts the handshake: no vec_valid, and the state returns to IDLE.

## Timing
- ir edge sampled at edge t: irr updates at t+1 and int_o at t+2 (two-cycle request latency).
- First inta at edge t: isr/irr update at t+1, and int_o is 0 from t+1.
- Second inta at edge t: vec/vec_valid valid at t+1 for one cycle.
- int_o may re-assert at t+2 if another candidate is valid.
- There is no limit on idle cycles between the two inta pulses.
- inta in consecutive cycles is legal.

## Test plan
- Fixed priority, NUM_IRQ=8, edge mode: ir = 0x24 rises together -> int_o at +2; first inta sets isr = 0x04 and irr = 0x20; second inta gives vec = 2 with vec_valid for 1 cycle.
- Nesting: isr = 0x04, ir5 raised -> int_o stays 0. Then ir1 raised -> int_o = 1. After the ack, isr = 0x06; non-specific EOI clears bit 1 and leaves isr = 0x04.
- AEOI with rotate_mode, NUM_IRQ=16: ack ch3 -> isr returns to 0 after the second inta and lp = 3. With irr = 0x0009 pending, the next ack selects ch0? No: ch3 is now lowest, so the order is 4..15, 0..3 and ch0 is selected.
- Spurious: ir3 pulse drops before the first inta, edge mode -> vec = 7, isr unchanged, irr = 0.
- Level mode with mask: imr = 0x01, ir = 0x01 held -> int_o stays 0. imr_wr with 0x00 -> int_o at +2; the ack gives vec = 0.
- Same-cycle events: specific EOI of ch2 and first inta selecting ch2 -> isr[2] = 1 afterwards. A rst_n pulse in ACK2 -> no vec_valid and all registers at their reset values.
